// File: rtl/packed_array_arbiter_pkg.sv
// Shared types and constants for the packed-array arbiter slice.
// The optional parity feature is selected with the PKD_ARB_PARITY_EN macro.
package packed_array_pkg;

   localparam int NREQ  = 4;
   localparam int BANKS = 2;
   localparam int ROWS  = 3;
   localparam int W     = 4;

   localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TOTAL = BANKS * ROWS;
   localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

   typedef logic [W-1:0] entry_t;
   typedef logic [BANKS-1:0][ROWS-1:0][W-1:0] array_t;

   // Row 0 sits in the least significant nibble.
   localparam logic [ROWS-1:0][W-1:0] INIT_IMAGE = {4'h6, 4'hE, 4'h5};

   typedef enum logic {INIT, SERVE} state_e;

   function automatic logic parity(entry_t d);
      return ^d;
   endfunction

endpackage

// File: rtl/packed_array_arbiter_if.sv
// Request/response bundle between the requesters and the packed-array arbiter.
interface packed_array_arbiter_if;
   import packed_array_pkg::*;

   logic [NREQ-1:0]         req_valid;
   logic [NREQ-1:0]         req_ready;
   logic [NREQ-1:0]         req_we;
   logic [NREQ-1:0][BW-1:0] req_bank;
   logic [NREQ-1:0][RW-1:0] req_row;
   logic [NREQ-1:0][W-1:0]  req_wdata;
   logic [NREQ-1:0]         rsp_valid;
   entry_t                  rsp_rdata;
   logic                    rsp_err;

   modport master (
      output req_valid, req_we, req_bank, req_row, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_bank, req_row, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/packed_array_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [IW-1:0] idx;

   // Scan from the farthest candidate back to ptr so the nearest one wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      idx     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = IW'((int'(ptr) + i) % N);
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/packed_array_arbiter.sv
// Round-robin shared access to a packed nibble array, loaded with a fixed image after reset.
// Define PKD_ARB_PARITY_EN to store per-entry even parity and add perr_sticky.
//
// state | meaning
// INIT  | writing INIT_IMAGE one entry per cycle, requests held off
// SERVE | one granted access per cycle, round-robin
module packed_array_arbiter
   import packed_array_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   packed_array_arbiter_if.slave  bus,
   output logic                   busy,
   output array_t                 snap
`ifdef PKD_ARB_PARITY_EN
   ,
   output logic                   perr_sticky
`endif
);

   state_e          state_q, state_d;
   logic [CW-1:0]   init_cnt;
   logic [BW-1:0]   init_bank;
   logic [RW-1:0]   init_row;
   logic            init_we, serve_en;

   array_t          arr;
   logic [IW-1:0]   ptr_q;
   logic [NREQ-1:0] arb_req, gnt;
   logic [IW-1:0]   gnt_idx;

   logic            g_any, g_we, in_range, wr_en, rd_en, par_bad;
   logic [BW-1:0]   g_bank, rd_bank;
   logic [RW-1:0]   g_row, rd_row;
   entry_t          g_wdata;

   always_ff @(posedge clk) begin
      if (rst) state_q <= INIT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:  if (init_cnt == '0) state_d = SERVE;
         SERVE: state_d = SERVE;
      endcase
   end

   always_comb begin
      busy     = rst || (state_q == INIT);
      init_we  = !rst && (state_q == INIT);
      serve_en = !rst && (state_q == SERVE);
   end

   // Down-counter ends INIT; bank/row walk the array row-major alongside it.
   always_ff @(posedge clk) begin
      if (rst) begin
         init_cnt  <= CW'(TOTAL - 1);
         init_bank <= '0;
         init_row  <= '0;
      end else if (init_we) begin
         init_cnt <= init_cnt - CW'(1);
         if (init_row == RW'(ROWS - 1)) begin
            init_row  <= '0;
            init_bank <= init_bank + BW'(1);
         end else begin
            init_row <= init_row + RW'(1);
         end
      end
   end

   assign arb_req       = serve_en ? bus.req_valid : '0;
   assign bus.req_ready = gnt;

   rr_arbiter #(.N(NREQ)) u_rr (
      .req     (arb_req),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign g_any    = |gnt;
   assign g_we     = bus.req_we[gnt_idx];
   assign g_bank   = bus.req_bank[gnt_idx];
   assign g_row    = bus.req_row[gnt_idx];
   assign g_wdata  = bus.req_wdata[gnt_idx];
   assign in_range = (int'(g_bank) < BANKS) && (int'(g_row) < ROWS);
   assign wr_en    = g_any && g_we && in_range;
   assign rd_en    = g_any && !g_we && in_range;
   assign rd_bank  = in_range ? g_bank : '0;
   assign rd_row   = in_range ? g_row : '0;

   always_ff @(posedge clk) begin
      if (init_we)    arr[init_bank][init_row] <= INIT_IMAGE[init_row];
      else if (wr_en) arr[g_bank][g_row]       <= g_wdata;
      snap <= arr;
   end

`ifdef PKD_ARB_PARITY_EN
   logic [BANKS-1:0][ROWS-1:0] par;

   always_ff @(posedge clk) begin
      if (init_we)    par[init_bank][init_row] <= parity(INIT_IMAGE[init_row]);
      else if (wr_en) par[g_bank][g_row]       <= parity(g_wdata);
   end

   assign par_bad = rd_en && (par[rd_bank][rd_row] != parity(arr[rd_bank][rd_row]));

   always_ff @(posedge clk) begin
      if (rst)          perr_sticky <= 1'b0;
      else if (par_bad) perr_sticky <= 1'b1;
   end
`else
   assign par_bad = 1'b0;
`endif

   // Reads sample the array at the grant edge; the response follows one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q         <= '0;
         bus.rsp_valid <= '0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.rsp_valid <= gnt;
         bus.rsp_rdata <= rd_en ? arr[rd_bank][rd_row] : '0;
         bus.rsp_err   <= g_any && (!in_range || par_bad);
         if (g_any) ptr_q <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IW'(1);
      end
   end

endmodule

// File: tb/tb_packed_array_arbiter.sv
// Directed bench for packed_array_arbiter with a cycle-level reference model.
// Build with PKD_ARB_PARITY_EN to also exercise the parity path.
module tb_packed_array_arbiter;
   import packed_array_pkg::*;

   logic   clk = 1'b0;
   logic   rst;
   logic   busy;
   array_t snap;
`ifdef PKD_ARB_PARITY_EN
   logic   perr_sticky;
`endif

   int total = 0;
   int bad   = 0;

   packed_array_arbiter_if bus();

   packed_array_arbiter dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy),
      .snap (snap)
`ifdef PKD_ARB_PARITY_EN
      ,
      .perr_sticky (perr_sticky)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [3:0] IMG [3] = '{4'h5, 4'hE, 4'h6};

   logic [3:0]      m_mem  [BANKS][ROWS];
   logic [3:0]      m_snap [BANKS][ROWS];
   bit              m_known [BANKS][ROWS];
   bit              m_snap_known [BANKS][ROWS];
   bit              m_perr [BANKS][ROWS];
   int              m_init_left = 0;
   int              m_ptr = 0;
   logic [NREQ-1:0] m_rv = '0;
   logic [3:0]      m_rdata = '0;
   logic            m_err = 1'b0;
   logic            m_sticky = 1'b0;
   bit              m_sync = 1'b0;
   bit              inject = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: check current outputs, then advance to the state after the next edge.
   always @(negedge clk) begin
      int w, b, r, k, j;
      bit inr;
      logic [NREQ-1:0] exp_rdy;
      if (inject) begin
         m_mem[0][1][0] = ~m_mem[0][1][0];
         m_perr[0][1]   = 1'b1;
      end
      w = -1;
      if (!rst && m_init_left == 0)
         for (int i = 0; i < NREQ; i++) begin
            j = (m_ptr + i) % NREQ;
            if (w < 0 && bus.req_valid[j]) w = j;
         end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;

      if (m_sync) begin
         chk("req_ready", bus.req_ready, exp_rdy);
         chk("rsp_valid", bus.rsp_valid, m_rv);
         chk("rsp_rdata", bus.rsp_rdata, m_rdata);
         chk("rsp_err", bus.rsp_err, m_err);
         chk("busy", busy, rst || m_init_left > 0);
         for (int bb = 0; bb < BANKS; bb++)
            for (int rr = 0; rr < ROWS; rr++)
               if (m_snap_known[bb][rr]) chk("snap_entry", snap[bb][rr], m_snap[bb][rr]);
`ifdef PKD_ARB_PARITY_EN
         chk("perr_sticky", perr_sticky, m_sticky);
`endif
      end

      for (int bb = 0; bb < BANKS; bb++)
         for (int rr = 0; rr < ROWS; rr++) begin
            m_snap[bb][rr]       = m_mem[bb][rr];
            m_snap_known[bb][rr] = m_known[bb][rr];
         end

      if (rst) begin
         m_init_left = BANKS * ROWS;
         m_ptr    = 0;
         m_rv     = '0;
         m_rdata  = '0;
         m_err    = 1'b0;
         m_sticky = 1'b0;
         m_sync   = 1'b1;
      end else if (m_init_left > 0) begin
         k = BANKS * ROWS - m_init_left;
         b = k / ROWS;
         r = k % ROWS;
         m_mem[b][r]   = IMG[r];
         m_known[b][r] = 1'b1;
         m_perr[b][r]  = 1'b0;
         m_init_left--;
         m_rv    = '0;
         m_rdata = '0;
         m_err   = 1'b0;
      end else if (w >= 0) begin
         b   = int'(bus.req_bank[w]);
         r   = int'(bus.req_row[w]);
         inr = (b < BANKS) && (r < ROWS);
         m_rv = exp_rdy;
         if (bus.req_we[w]) begin
            m_rdata = '0;
            m_err   = !inr;
            if (inr) begin
               m_mem[b][r]  = bus.req_wdata[w];
               m_perr[b][r] = 1'b0;
            end
         end else begin
            m_rdata = inr ? m_mem[b][r] : 4'h0;
            m_err   = !inr || (inr && m_perr[b][r]);
            if (inr && m_perr[b][r]) m_sticky = 1'b1;
         end
         m_ptr = (w + 1) % NREQ;
      end else begin
         m_rv    = '0;
         m_rdata = '0;
         m_err   = 1'b0;
      end
   end

   task automatic drive(input int i, input bit we, input int b, input int r, input logic [3:0] d);
      bus.req_valid[i] = 1'b1;
      bus.req_we[i]    = we;
      bus.req_bank[i]  = BW'(b);
      bus.req_row[i]   = RW'(r);
      bus.req_wdata[i] = d;
   endtask

   task automatic drop(input int i);
      bus.req_valid[i] = 1'b0;
   endtask

   task automatic wait_init(output int n);
      n = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         if (busy) n++;
         else break;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1);
   end

   initial begin
      int n;
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_we    = '0;
      bus.req_bank  = '0;
      bus.req_row   = '0;
      bus.req_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // init sequence and image
      wait_init(n);
      chk("busy_cycles", n, 6);
      @(negedge clk); #1;
      chk("snap_init", snap, 24'h6E56E5);

      // single reads
      @(posedge clk); #1; drive(0, 0, 1, 0, 4'h0);
      @(negedge clk); #1; chk("t2_ready0", bus.req_ready, 4'b0001);
      @(posedge clk); #1; drop(0); drive(2, 0, 0, 1, 4'h0);
      @(negedge clk); #1;
      chk("t2_rv0", bus.rsp_valid, 4'b0001);
      chk("t2_rdata0", bus.rsp_rdata, 4'h5);
      chk("t2_ready2", bus.req_ready, 4'b0100);
      @(posedge clk); #1; drop(2); drive(3, 0, 0, 0, 4'h0);
      @(negedge clk); #1;
      chk("t2_rv2", bus.rsp_valid, 4'b0100);
      chk("t2_rdata2", bus.rsp_rdata, 4'hE);
      @(posedge clk); #1; drop(3);

      // all four held: strict rotation with no idle cycle
      for (int i = 0; i < NREQ; i++) drive(i, 0, i % 2, i % 3, 4'h0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); #1;
         chk("t3_order", bus.req_ready, 4'b0001 << (k % 4));
         @(posedge clk);
      end
      #1;
      for (int i = 0; i < NREQ; i++) drop(i);

      // write then read-after-write, snap lag
      drive(1, 1, 1, 2, 4'h9);
      @(posedge clk); #1; drop(1); drive(3, 0, 1, 2, 4'h0);
      @(negedge clk); #1;
      chk("t4_snap_lag", snap[1][2], 4'h6);
      chk("t4_wr_rdata", bus.rsp_rdata, 4'h0);
      @(posedge clk); #1; drop(3);
      @(negedge clk); #1;
      chk("t4_rdata", bus.rsp_rdata, 4'h9);
      chk("t4_rv", bus.rsp_valid, 4'b1000);
      chk("t4_snap", snap[1][2], 4'h9);

      // out-of-range read and write
      @(posedge clk); #1; drive(0, 0, 0, 3, 4'h0);
      @(posedge clk); #1; drive(0, 1, 0, 3, 4'hF);
      @(negedge clk); #1;
      chk("t5_rd_err", bus.rsp_err, 1'b1);
      chk("t5_rd_data", bus.rsp_rdata, 4'h0);
      @(posedge clk); #1; drop(0);
      @(negedge clk); #1;
      chk("t5_wr_err", bus.rsp_err, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("t5_snap", snap, 24'h9E56E5);

      // reset with reads in flight
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 4'h0);
      drive(1, 0, 1, 1, 4'h0);
      drive(2, 0, 1, 2, 4'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
      chk("t6_rv_rst", bus.rsp_valid, 4'b0000);
      chk("t6_busy_rst", busy, 1'b1);
      chk("t6_ready_rst", bus.req_ready, 4'b0000);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) drop(i);
      wait_init(n);
      chk("t6_busy_cycles", n, 6);
      @(negedge clk); #1;
      chk("t6_snap", snap, 24'h6E56E5);

`ifdef PKD_ARB_PARITY_EN
      @(posedge clk); #1;
      inject = 1'b1;
      dut.arr[0][1][0] = ~dut.arr[0][1][0];
      @(negedge clk); #1;
      inject = 1'b0;
      @(posedge clk); #1; drive(0, 0, 0, 1, 4'h0);
      @(posedge clk); #1; drop(0);
      @(negedge clk); #1;
      chk("par_rdata", bus.rsp_rdata, 4'hF);
      chk("par_err", bus.rsp_err, 1'b1);
      chk("par_sticky", perr_sticky, 1'b1);
`endif

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
